// File: rtl/mem_responder_if.sv
// Request/response bus between the memory-request mux and the noun-store responder.
interface mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              mem_execute;
  logic [1:0]        mem_func;
  logic [ADDR_W-1:0] address1;
  logic [ADDR_W-1:0] address2;
  logic [DATA_W-1:0] write_data;
  logic              mem_ready;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] free_addr;
  logic [7:0]        error;

  modport master (
    output mem_execute, mem_func, address1, address2, write_data,
    input  mem_ready, read_data1, read_data2, free_addr, error
  );

  modport slave (
    input  mem_execute, mem_func, address1, address2, write_data,
    output mem_ready, read_data1, read_data2, free_addr, error
  );
endinterface

// File: rtl/mem_responder.sv
// Noun-store responder: serves GET/SET/GET_FREE with a bump allocator, one request in flight.
// Build macro MEM_SCRUB_EN adds a post-reset zero-fill of the RAM before requests are served.
module mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int FREE_BASE = 0
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  // state   | meaning
  // IDLE    | waiting for a request strobe
  // ACCESS  | RAM read/write or allocation for the latched request
  // RESPOND | mem_ready pulse, read data valid
  // SCRUB   | zero-filling the RAM after reset (MEM_SCRUB_EN builds only)
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] SCRUB   = 2'd3;

  localparam logic [1:0] FN_NONE = 2'd0;
  localparam logic [1:0] FN_GET  = 2'd1;
  localparam logic [1:0] FN_SET  = 2'd2;
  localparam logic [1:0] FN_FREE = 2'd3;

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] NIL = '1;

  logic [1:0]        state_q, state_d;
  logic [1:0]        func_q, func_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [ADDR_W-1:0] free_q, free_d;
  logic [3:0]        err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef MEM_SCRUB_EN
  logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
  logic              pend_q, pend_d;
  logic              scrub_take;
`endif

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    wdata_d   = wdata_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    free_d    = free_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = addr1_q;
    mem_wdata = wdata_q;
`ifdef MEM_SCRUB_EN
    scrub_cnt_d = scrub_cnt_q;
    pend_d      = pend_q;
    scrub_take  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.mem_execute) begin
          if (bus.mem_func != FN_NONE) begin
            func_d  = bus.mem_func;
            addr1_d = bus.address1;
            addr2_d = bus.address2;
            wdata_d = bus.write_data;
            state_d = ACCESS;
          end else begin
            err_d[2] = 1'b1;
          end
        end
      end

      ACCESS: begin
        case (func_q)
          FN_GET: begin
            rd1_d = mem_q[addr1_q];
            rd2_d = mem_q[addr2_q];
          end
          FN_SET: begin
            if (addr1_q == NIL) err_d[3] = 1'b1;
            else                mem_we   = 1'b1;
          end
          FN_FREE: begin
            rd1_d = {{(DATA_W-ADDR_W){1'b0}}, free_q};
            // The allocator parks on NIL rather than wrapping into live words.
            if (free_q == NIL) err_d[0] = 1'b1;
            else               free_d   = free_q + 1'b1;
          end
          default: ;
        endcase
        if (bus.mem_execute) err_d[1] = 1'b1;
        state_d = RESPOND;
      end

      RESPOND: begin
        if (bus.mem_execute) err_d[1] = 1'b1;
        state_d = IDLE;
      end

`ifdef MEM_SCRUB_EN
      SCRUB: begin
        mem_we      = 1'b1;
        mem_waddr   = ~scrub_cnt_q;
        mem_wdata   = '0;
        scrub_cnt_d = scrub_cnt_q - 1'b1;
        if (bus.mem_execute) begin
          if (bus.mem_func == FN_NONE) begin
            err_d[2] = 1'b1;
          end else if (pend_q) begin
            err_d[1] = 1'b1;
          end else begin
            scrub_take = 1'b1;
            pend_d     = 1'b1;
            func_d     = bus.mem_func;
            addr1_d    = bus.address1;
            addr2_d    = bus.address2;
            wdata_d    = bus.write_data;
          end
        end
        if (scrub_cnt_q == '0) begin
          pend_d  = 1'b0;
          state_d = (pend_q || scrub_take) ? ACCESS : IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef MEM_SCRUB_EN
      state_q     <= SCRUB;
      scrub_cnt_q <= NIL;
      pend_q      <= 1'b0;
`else
      state_q     <= IDLE;
`endif
      func_q  <= FN_NONE;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      free_q  <= ADDR_W'(FREE_BASE);
      err_q   <= '0;
    end else begin
`ifdef MEM_SCRUB_EN
      scrub_cnt_q <= scrub_cnt_d;
      pend_q      <= pend_d;
`endif
      state_q <= state_d;
      func_q  <= func_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wdata_q <= wdata_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      free_q  <= free_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; an aborted request never reaches this port since rst forces IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.mem_ready  = (state_q == RESPOND);
  assign bus.read_data1 = rd1_q;
  assign bus.read_data2 = rd2_q;
  assign bus.free_addr  = free_q;
  assign bus.error      = {4'b0000, err_q};
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table vectors, corner sequences and random traffic vs a model.
module tb_mem_responder;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_GET  = 2'd1;
  localparam logic [1:0] F_SET  = 2'd2;
  localparam logic [1:0] F_FREE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FREE_BASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [63:0] m_mem [int];
  int          written_q[$];
  int          m_free;
  logic [7:0]  m_err;
  logic [63:0] m_rd1, m_rd2;

  typedef struct {
    logic [1:0]  f;
    int          a1;
    int          a2;
    logic [63:0] wd;
    logic [63:0] e_rd1;
    logic [63:0] e_rd2;
    int          e_free;
    logic [7:0]  e_err;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input int a);
    if (m_mem.exists(a)) return m_mem[a];
    return 64'h0;
  endfunction

  task automatic model_reset();
    m_free = 0;
    m_err  = 8'h00;
    m_rd1  = 64'h0;
    m_rd2  = 64'h0;
`ifdef MEM_SCRUB_EN
    m_mem.delete();
    written_q.delete();
`endif
  endtask

  task automatic model_apply(input logic [1:0] f, input int a1, input int a2, input logic [63:0] wd);
    case (f)
      F_GET: begin
        m_rd1 = m_read(a1);
        m_rd2 = m_read(a2);
      end
      F_SET: begin
        if (a1 == DEPTH - 1) m_err[3] = 1'b1;
        else begin
          if (!m_mem.exists(a1)) written_q.push_back(a1);
          m_mem[a1] = wd;
        end
      end
      F_FREE: begin
        if (m_free == DEPTH - 1) begin
          m_err[0] = 1'b1;
          m_rd1    = 64'(DEPTH - 1);
        end else begin
          m_rd1 = 64'(m_free);
          m_free++;
        end
      end
      default: ;
    endcase
  endtask

  // called just after a rising edge; returns just after the edge that sampled the strobe
  task automatic strobe(input logic [1:0] f, input int a1, input int a2, input logic [63:0] wd);
    bus.mem_execute = 1'b1;
    bus.mem_func    = f;
    bus.address1    = ADDR_W'(a1);
    bus.address2    = ADDR_W'(a2);
    bus.write_data  = wd;
    @(posedge clk); #1;
    bus.mem_execute = 1'b0;
    bus.mem_func    = F_NONE;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!bus.mem_ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.mem_ready) lat = -1;
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.mem_ready) n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_req(input string nm, input logic [1:0] f, input int a1, input int a2,
                         input logic [63:0] wd);
    int lat;
    strobe(f, a1, a2, wd);
    wait_ready(lat);
    model_apply(f, a1, a2, wd);
    check({nm, " latency"}, 64'(lat), 64'd2);
    check({nm, " read_data1"}, bus.read_data1, m_rd1);
    check({nm, " read_data2"}, bus.read_data2, m_rd2);
    check({nm, " free_addr"}, 64'(bus.free_addr), 64'(m_free));
    check({nm, " error"}, 64'(bus.error), 64'(m_err));
    @(posedge clk); #1;
    check({nm, " single pulse"}, 64'(bus.mem_ready), 64'd0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
`ifdef MEM_SCRUB_EN
    repeat (DEPTH + 2) @(posedge clk);
`endif
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_execute = 1'b0;
    bus.mem_func    = F_NONE;
    repeat (2) @(posedge clk);
    #3;
    release_reset();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, npulse, f, a1, a2, gap;
    logic [63:0] wd;

    tbl[0] = '{F_SET,  5,    0, 64'hDEAD_BEEF,            64'h0,                   64'h0,         0, 8'h00};
    tbl[1] = '{F_GET,  5,    5, 64'h0,                    64'hDEAD_BEEF,           64'hDEAD_BEEF, 0, 8'h00};
    tbl[2] = '{F_FREE, 0,    0, 64'h0,                    64'd0,                   64'hDEAD_BEEF, 1, 8'h00};
    tbl[3] = '{F_FREE, 0,    0, 64'h0,                    64'd1,                   64'hDEAD_BEEF, 2, 8'h00};
    tbl[4] = '{F_FREE, 0,    0, 64'h0,                    64'd2,                   64'hDEAD_BEEF, 3, 8'h00};
    tbl[5] = '{F_SET,  6,    0, 64'h0123_4567_89AB_CDEF,  64'd2,                   64'hDEAD_BEEF, 3, 8'h00};
    tbl[6] = '{F_GET,  6,    5, 64'h0,                    64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF, 3, 8'h00};
    tbl[7] = '{F_SET,  1023, 0, 64'h55,                   64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF, 3, 8'h08};

    bus.mem_execute = 1'b0;
    bus.mem_func    = F_NONE;
    bus.address1    = '0;
    bus.address2    = '0;
    bus.write_data  = '0;
    do_reset();

    check("reset mem_ready", 64'(bus.mem_ready), 64'd0);
    check("reset read_data1", bus.read_data1, 64'd0);
    check("reset read_data2", bus.read_data2, 64'd0);
    check("reset free_addr", 64'(bus.free_addr), 64'd0);
    check("reset error", 64'(bus.error), 64'd0);

    // table vectors: SET/GET round trip, first allocations, NIL write
    for (int i = 0; i < 8; i++) begin
      strobe(tbl[i].f, tbl[i].a1, tbl[i].a2, tbl[i].wd);
      wait_ready(lat);
      model_apply(tbl[i].f, tbl[i].a1, tbl[i].a2, tbl[i].wd);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d read_data1", i), bus.read_data1, tbl[i].e_rd1);
      check($sformatf("vec%0d read_data2", i), bus.read_data2, tbl[i].e_rd2);
      check($sformatf("vec%0d free_addr", i), 64'(bus.free_addr), 64'(tbl[i].e_free));
      check($sformatf("vec%0d error", i), 64'(bus.error), 64'(tbl[i].e_err));
      @(posedge clk); #1;
      check($sformatf("vec%0d single pulse", i), 64'(bus.mem_ready), 64'd0);
    end

    // strobe during ACCESS is ignored and flagged
    run_req("set7", F_SET, 7, 0, 64'h7777);
    strobe(F_GET, 5, 6, 64'h0);
    bus.mem_execute = 1'b1;
    bus.mem_func    = F_SET;
    bus.address1    = 10'd7;
    bus.write_data  = 64'hBAD;
    @(posedge clk); #1;
    bus.mem_execute = 1'b0;
    bus.mem_func    = F_NONE;
    model_apply(F_GET, 5, 6, 64'h0);
    m_err[1] = 1'b1;
    check("busy strobe ready", 64'(bus.mem_ready), 64'd1);
    check("busy strobe rd1", bus.read_data1, 64'hDEAD_BEEF);
    check("busy strobe rd2", bus.read_data2, 64'h0123_4567_89AB_CDEF);
    check("busy strobe error", 64'(bus.error), 64'h0A);
    @(posedge clk); #1;
    count_pulses(4, npulse);
    check("busy strobe extra pulses", 64'(npulse), 64'd0);
    run_req("get7 after busy", F_GET, 7, 7, 64'h0);

    // func=0 strobe in IDLE
    strobe(F_NONE, 3, 3, 64'h0);
    count_pulses(4, npulse);
    m_err[2] = 1'b1;
    check("func0 pulses", 64'(npulse), 64'd0);
    check("func0 error", 64'(bus.error), 64'(m_err));

    // reset during ACCESS of a SET aborts the write
    run_req("set9", F_SET, 9, 0, 64'h9999_0000_1111);
    strobe(F_SET, 9, 0, 64'hBAD_BAD);
    rst = 1'b1;
    #1;
    check("midrst ready", 64'(bus.mem_ready), 64'd0);
    check("midrst error", 64'(bus.error), 64'd0);
    check("midrst free_addr", 64'(bus.free_addr), 64'd0);
    check("midrst read_data1", bus.read_data1, 64'd0);
    @(posedge clk); #1;
    check("midrst ready after edge", 64'(bus.mem_ready), 64'd0);
    release_reset();
    run_req("get9 after abort", F_GET, 9, 9, 64'h0);
    run_req("set nil", F_SET, 1023, 0, 64'h1234);
`ifdef MEM_SCRUB_EN
    run_req("get nil", F_GET, 1023, 1023, 64'h0);
`endif

    // random traffic against the model
    for (int k = 0; k < 200; k++) begin
      f  = $urandom_range(1, 3);
      wd = {$urandom, $urandom};
      a1 = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 31);
      a2 = $urandom_range(0, 31);
`ifdef MEM_SCRUB_EN
      if (f == F_GET) begin
        a1 = $urandom_range(0, 63);
        a2 = $urandom_range(0, 63);
      end
`else
      if (f == F_GET) begin
        if (written_q.size() == 0) f = F_SET;
        else begin
          a1 = written_q[$urandom_range(0, written_q.size() - 1)];
          a2 = written_q[$urandom_range(0, written_q.size() - 1)];
        end
      end
`endif
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      run_req("rand", 2'(f), a1, a2, wd);
    end

    // allocator exhaustion
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) run_req("alloc", F_FREE, 0, 0, 64'h0);
    check("alloc before nil free_addr", 64'(bus.free_addr), 64'd1023);
    run_req("alloc nil", F_FREE, 0, 0, 64'h0);
    check("alloc nil rd1", bus.read_data1, 64'd1023);
    check("alloc nil err0", 64'(bus.error[0]), 64'd1);
    check("alloc nil free_addr", 64'(bus.free_addr), 64'd1023);
    run_req("alloc nil again", F_FREE, 0, 0, 64'h0);

`ifdef MEM_SCRUB_EN
    // request during scrub is held, a second one is dropped
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    strobe(F_GET, 7, 7, 64'h0);
    @(posedge clk); #1;
    strobe(F_GET, 8, 8, 64'h0);
    lat = 0;
    while (!bus.mem_ready && lat < DEPTH + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("scrub pending latency", 64'(lat), 64'(DEPTH - 5));
    check("scrub pending rd1", bus.read_data1, 64'd0);
    check("scrub second req error", 64'(bus.error), 64'h02);
    @(posedge clk); #1;
    count_pulses(6, npulse);
    check("scrub dropped req pulses", 64'(npulse), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
